// File: rtl/nibble_serial_addsub_ctrl_if.sv
// nibble_serial_addsub_ctrl_if: request/result bus of the nibble-serial add/sub controller
interface nibble_serial_addsub_ctrl_if;
  logic start;
  logic mode;
  logic [15:0] opa;
  logic [15:0] opb;
  logic busy;
  logic done;
  logic [15:0] result;
  logic cout;
  logic ovf;
  modport master (output start, mode, opa, opb, input busy, done, result, cout, ovf);
  modport slave (input start, mode, opa, opb, output busy, done, result, cout, ovf);
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl: sequences a 16-bit add/sub through a shared 4-bit datapath, one nibble per cycle.
// Define ADDSUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module nibble_serial_addsub_ctrl (
  input  logic clk,
  input  logic rst,
  nibble_serial_addsub_ctrl_if.slave bus,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  output logic dp_m,
  output logic dp_cin,
  input  logic [3:0] dp_s,
  input  logic dp_cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [1:0] k;
  logic [15:0] a_q, b_q, res;
  logic m_q, c_q, run, accept;
  always_comb begin
    run = state == RUN;
    accept = bus.start && !run;
    state_n = accept ? RUN : run ? (k == 2'd3 ? DONE : RUN) : IDLE;
    dp_a = run ? a_q[{k, 2'b00} +: 4] : 4'd0;
    dp_b = run ? b_q[{k, 2'b00} +: 4] : 4'd0;
    dp_m = run && m_q;
    dp_cin = run && (k == 2'd0 ? m_q : c_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= 2'd0;
      a_q <= 16'd0;
      b_q <= 16'd0;
      m_q <= 1'b0;
      c_q <= 1'b0;
      res <= 16'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q <= bus.opa;
        b_q <= bus.opb;
        m_q <= bus.mode;
        k <= 2'd0;
      end else if (run) begin
        res[{k, 2'b00} +: 4] <= dp_s;
        c_q <= dp_cout;
        k <= k + 2'd1;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.result = res;
  assign bus.cout = c_q;
`ifdef ADDSUB_OVF_EN
  logic ovf_q;
  // overflow when both effective addend signs agree but the sum sign differs
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (run && k == 2'd3) ovf_q <= (a_q[15] == (b_q[15] ^ m_q)) && (dp_s[3] != a_q[15]);
  end
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: doc/nibble_serial_addsub_ctrl.md
NIBBLE_SERIAL_ADDSUB_CTRL -- requirements
Module: nibble_serial_addsub_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a 16-bit operation; sampled on rising clk.
REQ-005 mode  input  1  0 = add (opa+opb), 1 = subtract (opa-opb); captured with start.
REQ-006 opa  input  16  operand A; captured with start.
REQ-007 opb  input  16  operand B; captured with start.
REQ-008 busy  output  1  high while nibbles are being sequenced.
REQ-009 done  output  1  one-cycle pulse; result, cout and ovf valid.
REQ-010 result  output  16  registered result; held until the next accepted start completes.
REQ-011 cout  output  1  carry out of nibble 3; for subtract, 1 = no borrow (opa >= opb unsigned).
REQ-012 ovf  output  1  signed overflow flag (see Configuration).
REQ-013 dp_a  output  4  nibble of operand A to the shared 4-bit add/sub datapath.
REQ-014 dp_b  output  4  nibble of operand B to the datapath, uninverted.
REQ-015 dp_m  output  1  datapath mode; the datapath inverts B when 1.
REQ-016 dp_cin  output  1  datapath carry in.
REQ-017 dp_s  input  4  datapath sum, combinational from dp_* outputs: dp_a + (dp_b ^ {4{dp_m}}) + dp_cin.
REQ-018 dp_cout  input  1  datapath carry out.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE.
REQ-020 start SHALL be accepted only in IDLE or DONE; the block captures opa, opb and mode, clears nibble index k to 0, and enters RUN next cycle.
REQ-021 start in RUN SHALL be ignored with no effect on the operation in progress.
REQ-022 In RUN, nibble k SHALL be driven as dp_a = opa[4k+3:4k], dp_b = opb[4k+3:4k], dp_m = captured mode.
REQ-023 dp_cin SHALL be the captured mode for k = 0 and the registered dp_cout of nibble k-1 for k = 1..3.
REQ-024 At the end of each RUN cycle, dp_s SHALL be registered into result[4k+3:4k], dp_cout into the carry register, and k SHALL increment.
REQ-025 After k = 3, RUN SHALL go to DONE; latency is fixed: start accepted at cycle T, RUN at T+1..T+4, done = 1 at T+5.
REQ-026 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-027 DONE SHALL go to IDLE without start, or to RUN with start (back-to-back operations, no idle gap).
REQ-028 Outside RUN, dp_a, dp_b, dp_m and dp_cin SHALL be 0.
REQ-029 result bits not yet written in the current operation are unspecified until done; in IDLE, result SHALL hold the previous completed value.
REQ-030 Arithmetic is modulo 2^16; cout SHALL equal the nibble-3 dp_cout.

Reset
REQ-031 rst SHALL force IDLE, k = 0, busy = 0, done = 0, result = 0, cout = 0, ovf = 0 and all dp_* = 0 at the next clk edge.
REQ-032 rst during RUN SHALL abort the operation with no done pulse; rst has priority over start.

Configuration
REQ-033 With macro ADDSUB_OVF_EN defined, ovf SHALL be registered at the end of nibble 3 as (carry into bit 15) XOR (carry out of bit 15), computed from the operand sign bits and result[15].
REQ-034 Without ADDSUB_OVF_EN, ovf SHALL be constant 0 and no overflow logic SHALL be synthesized.

Verification
REQ-035 Add: mode=0, opa=0x1234, opb=0x0FFF -> done at T+5, result=0x2233, cout=0, ovf=0.
REQ-036 Subtract with borrow: mode=1, opa=0x0000, opb=0x0001 -> result=0xFFFF, cout=0; subtract with signed overflow: opa=0x8000, opb=0x0001 -> result=0x7FFF, cout=1, ovf=1 (ADDSUB_OVF_EN) / 0 (without).
REQ-037 Carry chain: mode=0, opa=0xFFFF, opb=0x0001 -> dp_cin = 0,1,1,1 over T+1..T+4; result=0x0000, cout=1.
REQ-038 start pulsed at T+2 with different operands -> ignored; busy stays 1 through T+4; the first result completes at T+5.
REQ-039 rst asserted at T+2 -> busy=0, done=0, result=0 from T+3; no done pulse; a new start then completes normally.
REQ-040 start held high across DONE -> second operation RUN at T+6..T+9, done at T+10, with correct results for both operations.
